// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle control sequencer for the 8-bit processor. Each instruction
//   steps through FETCH -> DECODE -> EXEC or MEM [-> WB] -> FETCH.
//   Data-memory strobes are held while the memory is busy. A bounded wait
//   (TIMEOUT) moves the FSM to HALT and raises a sticky mem_err.
//
//   Compile-time option:
//     ILLEGAL_TRAP_EN - when defined, an opcode >= 8 seen in DECODE traps to
//                       HALT and sets the sticky illegal_op flag. When it is
//                       undefined, such opcodes run as a NOP and illegal_op
//                       reads 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | load IR, PC+1
//   DECODE | latch opcode into op_q, choose EXEC or MEM
//   EXEC   | drive the op's control vector, instruction completes
//   MEM    | hold RM/WM until mem_ready, bounded by TIMEOUT
//   WB     | MR write-back (RM+WR), instruction completes
//   HALT   | all controls off, left only by reset

module multicycle_control_unit #(
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 15,
    parameter int TCNT_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            J,
    output logic            JC,
    output logic            INA,
    output logic            RM,
    output logic            WM,
    output logic            SIN,
    output logic            SOUT,
    output logic            WR,
    output logic            NEQ,
    output logic            ir_ld,
    output logic            pc_inc,
    output logic            instr_done,
    output logic [2:0]      state_o,
    output logic            mem_err,
    output logic            illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_R   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MFI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MW  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_J   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JCE = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JCN = OP_W'(7);

    // Wait-counter limit; a zero TIMEOUT disables the timeout entirely.
    localparam logic [TCNT_W-1:0] TO_LIMIT  = TCNT_W'(TIMEOUT);
    localparam bit                TO_ENABLE = (TIMEOUT != 0);

    // Datapath control vector: {J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ}
    typedef struct packed {
        logic j;
        logic jc;
        logic ina;
        logic rm;
        logic wm;
        logic sin;
        logic sout;
        logic wr;
        logic neq;
    } ctl_t;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [TCNT_W-1:0] wait_cnt;
    logic              mem_err_q;
    logic              is_mem_op;
    ctl_t              vec;
    ctl_t              ctl;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic op_illegal;

    // Codes above the base ISA only exist when the opcode is wider than 3 bits.
    if (OP_W > 3) begin : g_wide_op
        assign op_illegal = |opcode[OP_W-1:3];
    end else begin : g_base_op
        assign op_illegal = 1'b0;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign is_mem_op = (opcode == OP_MW) || (opcode == OP_MR);

    // Sequencer: state, latched opcode, memory wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op_q      <= '0;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q     <= opcode;
                    wait_cnt <= '0;
`ifdef ILLEGAL_TRAP_EN
                    if (op_illegal) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end else if (is_mem_op) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_EXEC;
                    end
`else
                    // Unknown codes fall through to EXEC and run as a NOP.
                    if (is_mem_op) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_EXEC;
                    end
`endif
                end
                S_EXEC: begin
                    state <= S_FETCH;
                end
                S_MEM: begin
                    // A ready on the timeout cycle still completes the access.
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= (op_q == OP_MR) ? S_WB : S_FETCH;
                    end else if (TO_ENABLE && (wait_cnt == TO_LIMIT)) begin
                        state     <= S_HALT;
                        mem_err_q <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + TCNT_W'(1);
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Per-opcode control vector taken from the latched opcode only.
    always_comb begin
        vec = '0;
        case (op_q)
            OP_R:    vec.sout = 1'b1;
            OP_MFI:  begin vec.ina = 1'b1; vec.sin = 1'b1; end
            OP_MW:   vec.wm = 1'b1;
            OP_MR:   begin vec.rm = 1'b1; vec.wr = 1'b1; end
            OP_J:    vec.j = 1'b1;
            OP_JCE:  vec.jc = 1'b1;
            OP_MB:   vec.wr = 1'b1;
            OP_JCN:  begin vec.jc = 1'b1; vec.neq = 1'b1; end
            default: vec = '0;
        endcase
    end

    // Output decode by state; only MW completion in MEM also looks at mem_ready.
    always_comb begin
        ctl        = '0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_EXEC: begin
                ctl        = vec;
                instr_done = 1'b1;
            end
            S_MEM: begin
                ctl = vec;
                // Register write for MR waits for WB, after the data has arrived.
                ctl.wr     = 1'b0;
                instr_done = mem_ready && (op_q == OP_MW);
            end
            S_WB: begin
                ctl.rm     = 1'b1;
                ctl.wr     = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

    assign J       = ctl.j;
    assign JC      = ctl.jc;
    assign INA     = ctl.ina;
    assign RM      = ctl.rm;
    assign WM      = ctl.wm;
    assign SIN     = ctl.sin;
    assign SOUT    = ctl.sout;
    assign WR      = ctl.wr;
    assign NEQ     = ctl.neq;
    assign state_o = state;
    assign mem_err = mem_err_q;

endmodule
